// File: rtl/key_event_scheduler_if.sv
// Event stream from the key scheduler to the UI/mode-control consumer.
// The head of the event FIFO is presented with a valid/ready handshake plus an overflow pulse.
interface key_event_scheduler_if #(
   parameter int NUM_KEYS = 4
);
   localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

   logic          evt_valid;
   logic          evt_ready;
   logic [KW-1:0] evt_key;
   logic [1:0]    evt_type;
   logic          evt_overflow;

   modport master (
      output evt_valid,
      output evt_key,
      output evt_type,
      output evt_overflow,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_key,
      input  evt_type,
      input  evt_overflow,
      output evt_ready
   );
endinterface

// File: rtl/key_event_scheduler.sv
// Classifies debounced active-low key presses as SHORT/LONG/REPEAT on a millisecond tick
// and funnels the events through a round-robin arbiter into a small event FIFO.
//
// state       | meaning
// S_IDLE      | key released, waiting for a falling edge
// S_PRESSED   | key held, counting ticks toward LONG_MS
// S_LONG_HELD | LONG issued, counting ticks toward each REPEAT
module key_event_scheduler #(
   parameter int NUM_KEYS   = 4,
   parameter int TICK_DIV   = 100_000,
   parameter int LONG_MS    = 1000,
   parameter int REPEAT_MS  = 200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_KEYS-1:0]   key_n,
   key_event_scheduler_if.master evt
);
   localparam int KW     = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
   localparam int PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int MS_MAX = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
   localparam int CW     = $clog2(MS_MAX + 1);
   localparam int AW     = $clog2(FIFO_DEPTH);

   localparam logic [AW:0] FIFO_FULL  = (AW+1)'(FIFO_DEPTH);
   localparam logic [1:0]  EVT_SHORT  = 2'b01;
   localparam logic [1:0]  EVT_LONG   = 2'b10;
   localparam logic [1:0]  EVT_REPEAT = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_PRESSED   = 2'd1,
      S_LONG_HELD = 2'd2
   } key_state_e;

   logic [PW-1:0]       pre_q;
   logic                tick;
   logic [NUM_KEYS-1:0] key_d;
   logic [NUM_KEYS-1:0] pend;
   logic [NUM_KEYS-1:0] grant;
   logic [NUM_KEYS-1:0] drop;
   logic [1:0]          pend_type [NUM_KEYS];

   logic [KW-1:0] rr_ptr;
   logic [KW-1:0] gnt_idx;
   logic          gnt_any;
   logic [AW:0]   count_q;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [KW-1:0] mem_key  [FIFO_DEPTH];
   logic [1:0]    mem_type [FIFO_DEPTH];
   logic          valid;
   logic          push;
   logic          pop;
   logic          ovf_q;

   // Free-running prescaler; never realigned to key activity.
   assign tick = (pre_q == PW'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= '0;
         key_d <= '1;
      end else begin
         pre_q <= tick ? '0 : pre_q + PW'(1);
         key_d <= key_n;
      end
   end

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_state_e    state_q, state_d;
      logic [CW-1:0] ms_cnt_q, ms_cnt_d;
      logic          fire_d, fire_q, pend_q;
      logic [1:0]    type_d, type_q, ptype_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q  <= S_IDLE;
            ms_cnt_q <= '0;
            fire_q   <= 1'b0;
            type_q   <= 2'b00;
         end else begin
            state_q  <= state_d;
            ms_cnt_q <= ms_cnt_d;
            fire_q   <= fire_d;
            type_q   <= type_d;
         end
      end

      // Release is checked before the tick so it wins a same-cycle threshold.
      always_comb begin
         state_d  = state_q;
         ms_cnt_d = ms_cnt_q;
         fire_d   = 1'b0;
         type_d   = 2'b00;
         case (state_q)
            S_IDLE: begin
               if (!key_n[i] && key_d[i]) begin
                  state_d  = S_PRESSED;
                  ms_cnt_d = '0;
               end
            end
            S_PRESSED: begin
               if (key_n[i]) begin
                  fire_d  = 1'b1;
                  type_d  = EVT_SHORT;
                  state_d = S_IDLE;
               end else if (tick) begin
                  if (ms_cnt_q == CW'(LONG_MS - 1)) begin
                     fire_d   = 1'b1;
                     type_d   = EVT_LONG;
                     state_d  = S_LONG_HELD;
                     ms_cnt_d = '0;
                  end else begin
                     ms_cnt_d = ms_cnt_q + CW'(1);
                  end
               end
            end
            S_LONG_HELD: begin
               if (key_n[i]) begin
                  state_d = S_IDLE;
               end else if (tick) begin
                  if (ms_cnt_q == CW'(REPEAT_MS - 1)) begin
                     fire_d   = 1'b1;
                     type_d   = EVT_REPEAT;
                     ms_cnt_d = '0;
                  end else begin
                     ms_cnt_d = ms_cnt_q + CW'(1);
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      // A slot being granted this cycle frees up for the incoming event.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            pend_q  <= 1'b0;
            ptype_q <= 2'b00;
         end else if (fire_q && (!pend_q || grant[i])) begin
            pend_q  <= 1'b1;
            ptype_q <= type_q;
         end else if (grant[i]) begin
            pend_q  <= 1'b0;
         end
      end

      assign pend[i]      = pend_q;
      assign pend_type[i] = ptype_q;
      assign drop[i]      = fire_q & pend_q & ~grant[i];
   end

   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      if (count_q != FIFO_FULL) begin
         for (int k = 0; k < NUM_KEYS; k++) begin
            if (!gnt_any && pend[k] && (k >= int'(rr_ptr))) begin
               gnt_any = 1'b1;
               gnt_idx = KW'(k);
            end
         end
         for (int k = 0; k < NUM_KEYS; k++) begin
            if (!gnt_any && pend[k] && (k < int'(rr_ptr))) begin
               gnt_any = 1'b1;
               gnt_idx = KW'(k);
            end
         end
      end
      if (gnt_any) grant[gnt_idx] = 1'b1;
   end

   assign valid = (count_q != '0);
   assign push  = gnt_any;
   assign pop   = valid & evt.evt_ready;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_key[wr_ptr]  <= gnt_idx;
         mem_type[wr_ptr] <= pend_type[gnt_idx];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         rr_ptr  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         ovf_q <= |drop;
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
            rr_ptr <= (gnt_idx == KW'(NUM_KEYS - 1)) ? '0 : gnt_idx + KW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign evt.evt_valid    = valid;
   assign evt.evt_key      = valid ? mem_key[rd_ptr] : '0;
   assign evt.evt_type     = valid ? mem_type[rd_ptr] : 2'b00;
   assign evt.evt_overflow = ovf_q;
endmodule

// File: tb/tb_key_event_scheduler.sv
// Bench for key_event_scheduler: table of press lengths, hand-written corner sequences and
// random key/ready traffic compared every cycle against a tick-counting reference model.
module tb_key_event_scheduler;
   localparam int NK = 4, TD = 4, LM = 5, RM = 3, DEPTH = 4;

   typedef struct packed {
      logic [1:0] key;
      logic [1:0] typ;
   } evt_t;

   typedef struct {
      int         key;
      int         hold;
      int         n_evt;
      logic [1:0] first_t;
      logic [1:0] last_t;
   } vec_t;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic [NK-1:0] key_n = '1;

   key_event_scheduler_if #(.NUM_KEYS(NK)) evt_if ();

   key_event_scheduler #(
      .NUM_KEYS(NK), .TICK_DIV(TD), .LONG_MS(LM), .REPEAT_MS(RM), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .key_n(key_n), .evt(evt_if)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_fail = 0;
   int ovf_seen = 0;
   evt_t dut_log[$];

   // reference model state
   evt_t          mq[$];
   int            m_cyc, m_rr;
   int            m_ticks [NK];
   bit [NK-1:0]   m_active, m_prev, m_pend, m_fire;
   logic [1:0]    m_ptype [NK];
   logic [1:0]    m_ftype [NK];
   bit            m_ovf;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_cyc = 0; m_rr = 0; m_ovf = 0;
      m_active = '0; m_prev = '1; m_pend = '0; m_fire = '0;
      for (int k = 0; k < NK; k++) begin
         m_ticks[k] = 0; m_ptype[k] = 2'b00; m_ftype[k] = 2'b00;
      end
   endtask

   // One clock edge: events from presses are counted in ticks since the press edge.
   task automatic model_step(input logic [NK-1:0] kn, input logic rdy);
      bit          tick;
      int          gnt;
      bit [NK-1:0] old_pend;
      evt_t        e;
      tick = ((m_cyc % TD) == TD - 1);
      gnt = -1;
      if (mq.size() < DEPTH)
         for (int off = 0; off < NK; off++)
            if (gnt < 0 && m_pend[(m_rr + off) % NK]) gnt = (m_rr + off) % NK;
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      if (gnt >= 0) begin
         e.key = 2'(gnt);
         e.typ = m_ptype[gnt];
         mq.push_back(e);
         m_rr = (gnt + 1) % NK;
      end
      old_pend = m_pend;
      m_ovf = 0;
      for (int k = 0; k < NK; k++) begin
         if (k == gnt) m_pend[k] = 0;
         if (m_fire[k]) begin
            if (old_pend[k] && k != gnt) m_ovf = 1;
            else begin
               m_pend[k] = 1;
               m_ptype[k] = m_ftype[k];
            end
         end
      end
      for (int k = 0; k < NK; k++) begin
         m_fire[k] = 0;
         m_ftype[k] = 2'b00;
         if (m_active[k]) begin
            if (kn[k]) begin
               if (m_ticks[k] < LM) begin m_fire[k] = 1; m_ftype[k] = 2'b01; end
               m_active[k] = 0;
            end else if (tick) begin
               m_ticks[k]++;
               if (m_ticks[k] == LM) begin m_fire[k] = 1; m_ftype[k] = 2'b10; end
               else if (m_ticks[k] > LM && ((m_ticks[k] - LM) % RM) == 0) begin
                  m_fire[k] = 1; m_ftype[k] = 2'b11;
               end
            end
         end else if (!kn[k] && m_prev[k]) begin
            m_active[k] = 1;
            m_ticks[k] = 0;
         end
         m_prev[k] = kn[k];
      end
      m_cyc++;
   endtask

   task automatic cycle();
      evt_t e, h;
      if (rst_n && evt_if.evt_valid && evt_if.evt_ready) begin
         e.key = evt_if.evt_key;
         e.typ = evt_if.evt_type;
         dut_log.push_back(e);
      end
      @(posedge clk);
      if (rst_n) model_step(key_n, evt_if.evt_ready);
      else model_reset();
      #1;
      if (evt_if.evt_overflow) ovf_seen++;
      h = (mq.size() != 0) ? mq[0] : '0;
      check("cycle_outputs",
            {26'd0, evt_if.evt_valid, evt_if.evt_key, evt_if.evt_type, evt_if.evt_overflow},
            {26'd0, (mq.size() != 0), h.key, h.typ, m_ovf});
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) cycle();
      rst_n = 1'b1;
   endtask

   task automatic short_press(input int k);
      key_n[k] = 1'b0;
      repeat (2) cycle();
      key_n[k] = 1'b1;
      repeat (3) cycle();
   endtask

   task automatic check_log(input string name, input int n, input int keys [8], input logic [1:0] typ);
      check({name, "_count"}, dut_log.size(), n);
      for (int j = 0; j < n && j < dut_log.size(); j++) begin
         check({name, "_key"}, dut_log[j].key, keys[j]);
         check({name, "_type"}, dut_log[j].typ, typ);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt [6];
      int   keys [8];
      int   rdy_pct [4];
      int   bad, head_bad;
      evt_t first_e, last_e;

      vt[0] = '{1, 10, 1, 2'b01, 2'b01};
      vt[1] = '{0,  3, 1, 2'b01, 2'b01};
      vt[2] = '{3, 16, 1, 2'b01, 2'b01};
      vt[3] = '{2, 25, 1, 2'b10, 2'b10};
      vt[4] = '{2, 40, 2, 2'b10, 2'b11};
      vt[5] = '{2, 60, 4, 2'b10, 2'b11};
      rdy_pct[0] = 100; rdy_pct[1] = 70; rdy_pct[2] = 30; rdy_pct[3] = 0;

      evt_if.evt_ready = 1'b1;
      model_reset();
      repeat (3) cycle();
      check("reset_valid", evt_if.evt_valid, 0);
      check("reset_overflow", evt_if.evt_overflow, 0);
      check("reset_key_type", {evt_if.evt_key, evt_if.evt_type}, 0);
      rst_n = 1'b1;
      repeat (2) cycle();

      // short press latency: valid two edges after the release edge, for one cycle
      key_n[1] = 1'b0;
      repeat (10) cycle();
      key_n[1] = 1'b1;
      cycle(); check("short_lat_k", evt_if.evt_valid, 0);
      cycle(); check("short_lat_k1", evt_if.evt_valid, 0);
      cycle(); check("short_lat_k2", {evt_if.evt_valid, evt_if.evt_key, evt_if.evt_type}, {1'b1, 2'd1, 2'b01});
      cycle(); check("short_lat_k3", evt_if.evt_valid, 0);
      repeat (4) cycle();

      // table: press length -> event count and types
      for (int v = 0; v < 6; v++) begin
         dut_log.delete();
         key_n[vt[v].key] = 1'b0;
         repeat (vt[v].hold) cycle();
         key_n[vt[v].key] = 1'b1;
         repeat (8) cycle();
         first_e = (dut_log.size() > 0) ? dut_log[0] : '0;
         last_e  = (dut_log.size() > 0) ? dut_log[dut_log.size()-1] : '0;
         bad = 0;
         foreach (dut_log[j]) if (dut_log[j].key != 2'(vt[v].key)) bad++;
         check("tbl_count", dut_log.size(), vt[v].n_evt);
         check("tbl_first_type", first_e.typ, vt[v].first_t);
         check("tbl_last_type", last_e.typ, vt[v].last_t);
         check("tbl_keys", bad, 0);
      end

      // round robin from rr_ptr=0, then from rr_ptr=2
      do_reset();
      dut_log.delete();
      key_n = '0; repeat (3) cycle(); key_n = '1; repeat (8) cycle();
      keys = '{0, 1, 2, 3, 0, 0, 0, 0};
      check_log("rr_first", 4, keys, 2'b01);
      dut_log.delete();
      short_press(1); repeat (3) cycle();
      key_n = '0; repeat (3) cycle(); key_n = '1; repeat (8) cycle();
      keys = '{1, 2, 3, 0, 1, 0, 0, 0};
      check_log("rr_second", 5, keys, 2'b01);

      // backpressure and overflow
      do_reset();
      evt_if.evt_ready = 1'b0;
      ovf_seen = 0;
      head_bad = 0;
      foreach (keys[j]) keys[j] = 0;
      keys[1] = 1; keys[2] = 2; keys[3] = 3;
      for (int j = 0; j < 6; j++) begin
         key_n[keys[j % 5]] = 1'b0;
         repeat (2) cycle();
         key_n[keys[j % 5]] = 1'b1;
         for (int c = 0; c < 3; c++) begin
            cycle();
            if (evt_if.evt_valid && {evt_if.evt_key, evt_if.evt_type} != 4'b0001) head_bad++;
         end
      end
      repeat (4) cycle();
      check("bp_overflow_pulses", ovf_seen, 1);
      check("bp_head_stable", head_bad, 0);
      check("bp_full_valid", evt_if.evt_valid, 1);
      dut_log.delete();
      evt_if.evt_ready = 1'b1;
      repeat (10) cycle();
      keys = '{0, 1, 2, 3, 0, 0, 0, 0};
      check_log("bp_drain", 5, keys, 2'b01);

      // release exactly on the LONG threshold tick, then one cycle later
      for (int v = 0; v < 2; v++) begin
         int t1, hold;
         t1 = m_cyc + 1;
         while ((t1 % TD) != TD - 1) t1++;
         hold = t1 + (LM - 1) * TD - m_cyc + v;
         dut_log.delete();
         key_n[3] = 1'b0;
         repeat (hold) cycle();
         key_n[3] = 1'b1;
         repeat (8) cycle();
         keys = '{3, 0, 0, 0, 0, 0, 0, 0};
         check_log(v == 0 ? "collide_short" : "collide_long", 1, keys, v == 0 ? 2'b01 : 2'b10);
      end

      // reset mid-operation with queued events and a held key
      do_reset();
      evt_if.evt_ready = 1'b0;
      short_press(1);
      short_press(2);
      key_n[0] = 1'b0;
      repeat (4) cycle();
      check("pre_reset_valid", evt_if.evt_valid, 1);
      rst_n = 1'b0;
      #1;
      check("async_reset_valid", evt_if.evt_valid, 0);
      check("async_reset_overflow", evt_if.evt_overflow, 0);
      model_reset();
      repeat (3) cycle();
      rst_n = 1'b1;
      evt_if.evt_ready = 1'b1;
      dut_log.delete();
      repeat (6) cycle();
      key_n[0] = 1'b1;
      repeat (8) cycle();
      keys = '{0, 0, 0, 0, 0, 0, 0, 0};
      check_log("reset_fresh_press", 1, keys, 2'b01);

      // random keys and backpressure against the model
      do_reset();
      for (int blk = 0; blk < 12; blk++) begin
         for (int c = 0; c < 250; c++) begin
            for (int k = 0; k < NK; k++)
               if ($urandom_range(0, 15) == 0) key_n[k] = ~key_n[k];
            evt_if.evt_ready = ($urandom_range(0, 99) < rdy_pct[blk % 4]);
            cycle();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
